// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter behind a 2**FIFO_ADDR_W byte FIFO. The line falls one clock after a push lands in an empty FIFO.
// The host never stalls: a push into a full FIFO is dropped and flagged with a one-cycle o_Overflow pulse.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_ADDR_W  = 2
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Full,
  output logic       o_Empty,
  output logic       o_Overflow,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);
  localparam int DEPTH = 1 << FIFO_ADDR_W;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]             fifo_mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr;
  logic [FIFO_ADDR_W-1:0] rd_ptr;
  logic [FIFO_ADDR_W:0]   fifo_cnt;
  logic [FIFO_ADDR_W:0]   fifo_cnt_nxt;
  logic                   push;
  logic                   pop;

  state_t     state;
  state_t     state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [CNT_W-1:0] clk_cnt_nxt;
  logic [2:0] bit_idx;
  logic [2:0] bit_idx_nxt;
  logic [7:0] shift_dat;
  logic [7:0] shift_dat_nxt;
  logic       serial_nxt;
  logic       active_nxt;
  logic       done_nxt;

  // A push is accepted only against the registered full flag, so a same-cycle pop never rescues it
  assign push = i_Tx_DV && !o_Full;

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_nxt = fifo_cnt + (FIFO_ADDR_W+1)'(1);
      2'b01:   fifo_cnt_nxt = fifo_cnt - (FIFO_ADDR_W+1)'(1);
      default: fifo_cnt_nxt = fifo_cnt;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      o_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
      fifo_cnt   <= fifo_cnt_nxt;
      o_Full     <= (fifo_cnt_nxt == (FIFO_ADDR_W+1)'(DEPTH));
      o_Empty    <= (fifo_cnt_nxt == '0);
      o_Overflow <= i_Tx_DV && o_Full;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) fifo_mem[wr_ptr] <= i_Tx_Byte;
  end

  always_comb begin
    state_nxt     = state;
    clk_cnt_nxt   = clk_cnt;
    bit_idx_nxt   = bit_idx;
    shift_dat_nxt = shift_dat;
    serial_nxt    = o_Tx_Serial;
    active_nxt    = o_Tx_Active;
    done_nxt      = 1'b0;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        serial_nxt  = 1'b1;
        active_nxt  = 1'b0;
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (fifo_cnt != '0) begin
          pop           = 1'b1;
          shift_dat_nxt = fifo_mem[rd_ptr];
          serial_nxt    = 1'b0;
          active_nxt    = 1'b1;
          state_nxt     = START;
        end
      end
      START: begin
        if (clk_cnt == LAST_CLK) begin
          clk_cnt_nxt   = '0;
          bit_idx_nxt   = '0;
          serial_nxt    = shift_dat[0];
          shift_dat_nxt = {1'b0, shift_dat[7:1]};
          state_nxt     = DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt == LAST_CLK) begin
          clk_cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            serial_nxt = 1'b1;
            state_nxt  = STOP;
          end else begin
            bit_idx_nxt   = bit_idx + 3'd1;
            serial_nxt    = shift_dat[0];
            shift_dat_nxt = {1'b0, shift_dat[7:1]};
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt == LAST_CLK) begin
          clk_cnt_nxt = '0;
          done_nxt    = 1'b1;
          active_nxt  = 1'b0;
          state_nxt   = IDLE;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        serial_nxt  = 1'b1;
        active_nxt  = 1'b0;
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_dat   <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      clk_cnt     <= clk_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift_dat   <= shift_dat_nxt;
      o_Tx_Serial <= serial_nxt;
      o_Tx_Active <= active_nxt;
      o_Tx_Done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: a serial-line monitor decodes every frame and checks it against a queue of expected bytes.
module tb_uart_tx_buffered;
  localparam int CPB = 4;

  typedef struct {
    logic       dv;
    logic [7:0] dat;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       full, empty, ovf, active, ser, done;
  logic       dv2 = 1'b0;
  logic [7:0] tx_byte2 = 8'h00;
  logic       full2, empty2, ovf2, active2, ser2, done2;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  vec_t       vecs[7];

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_W(2)) dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(tx_byte),
    .o_Full(full), .o_Empty(empty), .o_Overflow(ovf),
    .o_Tx_Active(active), .o_Tx_Serial(ser), .o_Tx_Done(done)
  );

  uart_tx_buffered #(.CLKS_PER_BIT(2), .FIFO_ADDR_W(2)) dut2 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv2), .i_Tx_Byte(tx_byte2),
    .o_Full(full2), .o_Empty(empty2), .o_Overflow(ovf2),
    .o_Tx_Active(active2), .o_Tx_Serial(ser2), .o_Tx_Done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    i = 0;
    while (!done && i < limit) begin
      @(negedge clk);
      i++;
    end
    check_bit({name, "_done_seen"}, done, 1'b1);
  endtask

  // Single 0xA5 frame with exact per-clock line check; sel picks the CLKS_PER_BIT=2 instance
  task automatic single_byte(input logic sel, input int cpb);
    logic [9:0] fr;
    fr = 10'b1_10100101_0;
    if (sel) begin
      dv2 = 1'b1; tx_byte2 = 8'hA5;
    end else begin
      dv = 1'b1; tx_byte = 8'hA5; exp_q.push_back(8'hA5);
    end
    @(negedge clk);
    dv = 1'b0; dv2 = 1'b0;
    check_bit("sb_line_before_fall", sel ? ser2 : ser, 1'b1);
    check_bit("sb_active_before_fall", sel ? active2 : active, 1'b0);
    for (int k = 0; k < 10 * cpb; k++) begin
      @(negedge clk);
      check_bit("sb_line", sel ? ser2 : ser, fr[k / cpb]);
      check_bit("sb_active", sel ? active2 : active, 1'b1);
      check_bit("sb_done_early", sel ? done2 : done, 1'b0);
    end
    @(negedge clk);
    check_bit("sb_done_pulse", sel ? done2 : done, 1'b1);
    check_bit("sb_active_end", sel ? active2 : active, 1'b0);
    check_bit("sb_line_idle", sel ? ser2 : ser, 1'b1);
    @(negedge clk);
    check_bit("sb_done_one_cycle", sel ? done2 : done, 1'b0);
  endtask

  initial begin : serial_monitor
    logic [9:0] bits;
    logic       frame_ok;
    logic       aborted;
    logic       prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !ser) begin
        starts.push_back(cyc);
        frame_ok = 1'b1;
        aborted  = 1'b0;
        bits     = '0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (s == 0) bits[b] = ser;
            else if (ser !== bits[b]) frame_ok = 1'b0;
          end
        end
        if (!aborted) begin
          check_bit("frame_bits_stable", frame_ok, 1'b1);
          check_bit("frame_start_bit", bits[0], 1'b0);
          check_bit("frame_stop_bit", bits[9], 1'b1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got %02h expected no frame", bits[8:1]);
          end else begin
            check_byte("frame_byte", bits[8:1], exp_q.pop_front());
          end
        end
      end
      prev = ser;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int cnt;
    vecs[0] = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};  // pop of 0x00 coincides: count stays 1
    vecs[2] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

    #3 rst_n = 1'b0;
    #1;
    check_bit("rst_line", ser, 1'b1);
    check_bit("rst_active", active, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_ovf", ovf, 1'b0);
    check_bit("rst_full", full, 1'b0);
    check_bit("rst_empty", empty, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("post_rst_empty", empty, 1'b1);

    single_byte(1'b0, CPB);
    repeat (2) @(negedge clk);
    single_byte(1'b1, 2);
    repeat (2) @(negedge clk);

    // Back-to-back frames and overflow
    starts.delete();
    for (int i = 0; i < 7; i++) begin
      dv = vecs[i].dv;
      tx_byte = vecs[i].dat;
      if (vecs[i].dv && !vecs[i].exp_ovf) exp_q.push_back(vecs[i].dat);
      @(negedge clk);
      check_bit("vec_full", full, vecs[i].exp_full);
      check_bit("vec_empty", empty, vecs[i].exp_empty);
      check_bit("vec_ovf", ovf, vecs[i].exp_ovf);
    end
    dv = 1'b0;
    wait_done("b2b_first", 100);
    check_bit("b2b_full_until_pop", full, 1'b1);
    @(negedge clk);
    check_bit("b2b_full_drops_on_pop", full, 1'b0);
    check_bit("b2b_not_empty", empty, 1'b0);
    cnt = 0;
    for (int i = 0; i < 200 && cnt < 4; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check_int("b2b_done_pulses", cnt, 4);
    check_int("b2b_frame_count", starts.size(), 5);
    for (int i = 1; i < starts.size(); i++)
      check_int("b2b_frame_period", starts[i] - starts[i-1], 10 * CPB + 1);
    repeat (3) @(negedge clk);

    // Push on the exact IDLE pop cycle with one byte queued
    dv = 1'b1; tx_byte = 8'h5A; exp_q.push_back(8'h5A);
    @(negedge clk);
    tx_byte = 8'hA7; exp_q.push_back(8'hA7);
    @(negedge clk);
    dv = 1'b0;
    check_bit("pp_empty", empty, 1'b0);
    check_bit("pp_full", full, 1'b0);
    repeat (40) @(negedge clk);
    check_bit("pp_done_a", done, 1'b1);
    check_bit("pp_still_one_queued", empty, 1'b0);
    @(negedge clk);
    check_bit("pp_empty_after_second_pop", empty, 1'b1);
    check_bit("pp_active_second", active, 1'b1);
    wait_done("pp_second", 60);
    repeat (3) @(negedge clk);

    // Reset mid-frame, then a clean frame
    dv = 1'b1; tx_byte = 8'h96; exp_q.push_back(8'h96);
    @(negedge clk);
    tx_byte = 8'h11; exp_q.push_back(8'h11);
    @(negedge clk);
    tx_byte = 8'h22; exp_q.push_back(8'h22);
    @(negedge clk);
    dv = 1'b0;
    repeat (16) @(negedge clk);
    check_bit("abort_line_bit3_low", ser, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_bit("abort_rst_line", ser, 1'b1);
    check_bit("abort_rst_active", active, 1'b0);
    check_bit("abort_rst_done", done, 1'b0);
    check_bit("abort_rst_ovf", ovf, 1'b0);
    check_bit("abort_rst_full", full, 1'b0);
    check_bit("abort_rst_empty", empty, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("abort_post_empty", empty, 1'b1);
    check_bit("abort_post_line", ser, 1'b1);
    dv = 1'b1; tx_byte = 8'h12; exp_q.push_back(8'h12);
    @(negedge clk);
    dv = 1'b0;
    wait_done("abort_clean", 60);
    repeat (50) @(negedge clk);
    check_bit("abort_idle_active", active, 1'b0);
    check_bit("abort_idle_empty", empty, 1'b1);
    check_int("all_frames_sent", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
